// File: rtl/ledr_pattern_sequencer.sv
// Registered next-pattern generator for LEDR[9:0]: 1-to-10 bar fill followed by a cyclic effect loop.
// The effect loop is built only when LEDR_EFFECTS_EN is defined; otherwise 0x3FF wraps to 0x000.
module ledr_pattern_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [9:0] in,
    output logic [9:0] out
);

    localparam logic [9:0] P0  = 10'h000;
    localparam logic [9:0] P10 = 10'h3FF;
`ifdef LEDR_EFFECTS_EN
    localparam logic [9:0] E1A = 10'h2AA;
    localparam logic [9:0] E1B = 10'h155;
    localparam logic [9:0] E2A = 10'h249;
    localparam logic [9:0] E2B = 10'h124;
    localparam logic [9:0] E2C = 10'h092;
    localparam logic [9:0] EON = 10'h3FF;
`endif

    logic [9:0] out_q;
    logic [9:0] out_d;

    // Successor of a decoded pattern; anything off-sequence recovers to P0.
    function automatic logic [9:0] next_pattern(input logic [9:0] cur);
        logic [9:0] nxt;
        nxt = P0;
        case (cur)
            10'h000: nxt = 10'h001;
            10'h001: nxt = 10'h003;
            10'h003: nxt = 10'h007;
            10'h007: nxt = 10'h00F;
            10'h00F: nxt = 10'h01F;
            10'h01F: nxt = 10'h03F;
            10'h03F: nxt = 10'h07F;
            10'h07F: nxt = 10'h0FF;
            10'h0FF: nxt = 10'h1FF;
            10'h1FF: nxt = P10;
`ifdef LEDR_EFFECTS_EN
            // P10 and EON share 0x3FF, so both enter the effect loop.
            P10:     nxt = E1A;
            E1A:     nxt = E1B;
            E1B:     nxt = E2A;
            E2A:     nxt = E2B;
            E2B:     nxt = E2C;
            E2C:     nxt = EON;
`else
            P10:     nxt = P0;
`endif
            default: nxt = P0;
        endcase
        return nxt;
    endfunction

    // Next-state selection: advance one step on enable, otherwise hold.
    always_comb begin
        out_d = out_q;
        if (en) begin
            out_d = next_pattern(in);
        end else begin
            out_d = out_q;
        end
    end

    // Pattern register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= P0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_ledr_pattern_sequencer.sv
// Self-checking bench for ledr_pattern_sequencer: directed sequence checks plus randomized stimulus
// against a behavioural successor model; honours LEDR_EFFECTS_EN the same way as the design.
module tb_ledr_pattern_sequencer;

    logic       clk;
    logic       reset;
    logic       en;
    logic [9:0] in;
    logic [9:0] out;

    int checks;
    int errors;
    bit cmp_on;
    logic [9:0] exp_out;

    ledr_pattern_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .in    (in),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LEDR_EFFECTS_EN
    localparam bit EFFECTS = 1'b1;
`else
    localparam bit EFFECTS = 1'b0;
`endif

    function automatic logic [9:0] model_next(input logic [9:0] cur);
        logic [9:0] eff [6];
        logic [10:0] bar;
        eff[0] = 10'h2AA; eff[1] = 10'h155; eff[2] = 10'h249;
        eff[3] = 10'h124; eff[4] = 10'h092; eff[5] = 10'h3FF;
        for (int n = 0; n < 10; n++) begin
            bar = (11'd1 << n) - 11'd1;
            if (cur == bar[9:0]) begin
                bar = (11'd1 << (n + 1)) - 11'd1;
                return bar[9:0];
            end
        end
        if (cur == 10'h3FF) return EFFECTS ? 10'h2AA : 10'h000;
        if (EFFECTS) begin
            for (int i = 0; i < 5; i++) begin
                if (cur == eff[i]) return eff[i + 1];
            end
        end
        return 10'h000;
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%03h expected 0x%03h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) exp_out <= 10'h000;
        else if (en) exp_out <= model_next(in);
    end

    always @(negedge clk) begin
        if (cmp_on) check("model", out, exp_out);
    end

    task automatic step_fb(input string name, input logic [9:0] req);
        en = 1'b1;
        in = out;
        @(negedge clk);
        check(name, out, req);
    endtask

    logic [9:0] bar_seq [10];
    logic [9:0] eff_seq [6];
    logic [9:0] pool [8];

    initial begin
        checks = 0;
        errors = 0;
        cmp_on = 1'b0;
        reset  = 1'b0;
        en     = 1'b1;
        in     = 10'h000;
        bar_seq = '{10'h001, 10'h003, 10'h007, 10'h00F, 10'h01F,
                    10'h03F, 10'h07F, 10'h0FF, 10'h1FF, 10'h3FF};
        eff_seq = '{10'h2AA, 10'h155, 10'h249, 10'h124, 10'h092, 10'h3FF};
        pool    = '{10'h3FF, 10'h2AA, 10'h155, 10'h249, 10'h124, 10'h092, 10'h0F0, 10'h1FF};

        // Model pinned against hand-derived successors.
        check("pin_000", model_next(10'h000), 10'h001);
        check("pin_1ff", model_next(10'h1FF), 10'h3FF);
        check("pin_3ff", model_next(10'h3FF), EFFECTS ? 10'h2AA : 10'h000);
        check("pin_092", model_next(10'h092), EFFECTS ? 10'h3FF : 10'h000);
        check("pin_0f0", model_next(10'h0F0), 10'h000);

        @(negedge clk);
        check("reset_hold", out, 10'h000);
        cmp_on = 1'b1;

        // Hold with enable low after release.
        reset = 1'b1;
        en = 1'b0;
        in = out;
        @(negedge clk);
        check("hold_000", out, 10'h000);

        for (int i = 0; i < 10; i++) step_fb("bar", bar_seq[i]);
        en = 1'b0;
        in = out;
        @(negedge clk);
        check("hold_3ff", out, 10'h3FF);

        if (EFFECTS) begin
            for (int l = 0; l < 2; l++)
                for (int i = 0; i < 6; i++) step_fb("effect", eff_seq[i]);
        end else begin
            step_fb("wrap", 10'h000);
            step_fb("wrap_next", 10'h001);
        end

        // Unlisted pattern recovers to P0, then continues.
        en = 1'b1;
        in = 10'h0F0;
        @(negedge clk);
        check("recover", out, 10'h000);
        step_fb("recover_next", 10'h001);

        // Effect patterns must fall back to P0 without the effect loop.
        in = 10'h2AA;
        @(negedge clk);
        check("e1a_succ", out, EFFECTS ? 10'h155 : 10'h000);

        // Asynchronous clear between edges, and reset beats enable.
        in = 10'h1FF;
        @(negedge clk);
        check("pre_reset", out, 10'h3FF);
        #2 reset = 1'b0;
        #1 check("async_clear", out, 10'h000);
        @(negedge clk);
        check("reset_wins", out, 10'h000);
        reset = 1'b1;
        in = 10'h000;
        @(negedge clk);
        check("first_after_reset", out, 10'h001);

        // Randomized stimulus checked by the compare process against the model.
        for (int c = 0; c < 3000; c++) begin
            int sel;
            en = ($urandom_range(3) != 0);
            sel = $urandom_range(9);
            if (sel < 6) in = out;
            else if (sel < 8) in = pool[$urandom_range(7)];
            else in = 10'($urandom);
            if ($urandom_range(49) == 0) begin
                #2 reset = 1'b0;
                #1 check("rand_async_clear", out, 10'h000);
                @(negedge clk);
                reset = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
